mem_stage_sequencer: RTL and testbench

- Consumer end of the EX/MEM pipeline register. Takes the memory-stage fields and runs each load/store against a one-word-per-block write-back data cache and a fixed-latency main memory.
- Stalls the pipeline on a miss and sequences writeback and refill.
- Registers the result into the MEM/WB fields for the writeback stage.
- Sits between the EX/MEM buffer outputs, the data cache, main memory and the register-file writeback.

---
 rtl/mem_stage_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_mem_stage_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sequencer.sv
// MEM-stage sequencer: runs EX/MEM loads/stores against a write-back data cache and a fixed-latency main memory.
// Hits take one cycle. A miss stalls for 1+MEM_LATENCY cycles when clean and 1+2*MEM_LATENCY when dirty. Optional counters: MEM_STAGE_PERF_EN.
module mem_stage_sequencer #(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        valid_mem,
    input  logic        load_mem,
    input  logic        store_mem,
    input  logic        is_word_mem,
    input  logic [31:0] addr_mem,
    input  logic [31:0] store_data_mem,
    input  logic [4:0]  rd_num_mem,
    input  logic        register_write_mem,
    input  logic        halted_mem,
    input  logic        cache_hit,
    input  logic        cache_dirty,
    input  logic [31:0] cache_victim_addr,
    input  logic [31:0] cache_rdata,
    output logic        cache_we,
    output logic [3:0]  cache_byte_en,
    output logic [31:0] cache_wdata,
    output logic        cache_input_type,
    output logic        cache_set_dirty,
    output logic        cache_set_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_halted
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0] perf_miss_count,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_REFILL    = 2'd2;
    localparam logic [7:0] LAST_CNT    = 8'(MEM_LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] victim_q, victim_d;
    logic        miss_start;

    logic        wb_valid_q, wb_reg_write_q, wb_halted_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    logic        mem_op, is_store;
    logic [7:0]  lane_byte;
    logic [31:0] load_result;

    // Load wins when both load and store are flagged.
    assign mem_op   = valid_mem & (load_mem | store_mem);
    assign is_store = store_mem & ~load_mem;

    assign lane_byte   = cache_rdata[{addr_mem[1:0], 3'b000} +: 8];
    assign load_result = is_word_mem ? cache_rdata : {{24{lane_byte[7]}}, lane_byte};

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        victim_d         = victim_q;
        miss_start       = 1'b0;
        cache_we         = 1'b0;
        cache_byte_en    = 4'b1111;
        cache_wdata      = store_data_mem;
        cache_input_type = 1'b0;
        cache_set_dirty  = 1'b0;
        cache_set_valid  = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = {addr_mem[31:2], 2'b00};
        mem_wdata        = cache_rdata;
        stall            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    if (cache_hit) begin
                        if (is_store) begin
                            cache_we        = 1'b1;
                            cache_set_dirty = 1'b1;
                            cache_set_valid = 1'b1;
                            if (!is_word_mem) begin
                                cache_byte_en = 4'b0001 << addr_mem[1:0];
                                cache_wdata   = {4{store_data_mem[7:0]}};
                            end
                        end
                    end else begin
                        stall      = 1'b1;
                        cnt_d      = 8'd0;
                        miss_start = 1'b1;
                        if (cache_dirty) begin
                            state_d  = S_WRITEBACK;
                            victim_d = cache_victim_addr;
                        end else begin
                            state_d = S_REFILL;
                        end
                    end
                end
            end
            S_WRITEBACK: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = victim_q;
                stall    = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_REFILL;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_REFILL: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cache_we         = 1'b1;
                    cache_input_type = 1'b1;
                    cache_wdata      = mem_rdata;
                    cache_byte_en    = 4'b1111;
                    cache_set_valid  = 1'b1;
                    state_d          = S_IDLE;
                    cnt_d            = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // An aborting reset must never commit a partial refill or store.
        if (rst_b) begin
            cache_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q        <= S_IDLE;
            cnt_q          <= 8'd0;
            victim_q       <= 32'd0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= 32'd0;
            wb_halted_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
            if (!stall) begin
                wb_valid_q     <= valid_mem;
                wb_reg_write_q <= register_write_mem & valid_mem;
                wb_rd_q        <= rd_num_mem;
                wb_data_q      <= load_mem ? load_result : addr_mem;
                wb_halted_q    <= halted_mem;
            end else begin
                // Bubble while stalled; the replay carries the real result and halt.
                wb_valid_q     <= 1'b0;
                wb_reg_write_q <= 1'b0;
                wb_halted_q    <= 1'b0;
            end
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_halted    = wb_halted_q;

`ifdef MEM_STAGE_PERF_EN
    logic [31:0] perf_miss_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            perf_miss_q  <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (miss_start) perf_miss_q  <= perf_miss_q + 32'd1;
            if (stall)      perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_miss_count   = perf_miss_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Directed self-checking bench for mem_stage_sequencer (MEM_LATENCY=4).
module tb_mem_stage_sequencer;

    logic        clk;
    logic        rst_b;
    logic        valid_mem, load_mem, store_mem, is_word_mem;
    logic [31:0] addr_mem, store_data_mem;
    logic [4:0]  rd_num_mem;
    logic        register_write_mem, halted_mem;
    logic        cache_hit, cache_dirty;
    logic [31:0] cache_victim_addr, cache_rdata;
    logic        cache_we;
    logic [3:0]  cache_byte_en;
    logic [31:0] cache_wdata;
    logic        cache_input_type, cache_set_dirty, cache_set_valid;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_halted;
`ifdef MEM_STAGE_PERF_EN
    logic [31:0] perf_miss_count, perf_stall_cycles;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage_sequencer #(.MEM_LATENCY(4)) dut (
        .clk(clk), .rst_b(rst_b),
        .valid_mem(valid_mem), .load_mem(load_mem), .store_mem(store_mem),
        .is_word_mem(is_word_mem), .addr_mem(addr_mem), .store_data_mem(store_data_mem),
        .rd_num_mem(rd_num_mem), .register_write_mem(register_write_mem), .halted_mem(halted_mem),
        .cache_hit(cache_hit), .cache_dirty(cache_dirty), .cache_victim_addr(cache_victim_addr),
        .cache_rdata(cache_rdata), .cache_we(cache_we), .cache_byte_en(cache_byte_en),
        .cache_wdata(cache_wdata), .cache_input_type(cache_input_type),
        .cache_set_dirty(cache_set_dirty), .cache_set_valid(cache_set_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_halted(wb_halted)
`ifdef MEM_STAGE_PERF_EN
        , .perf_miss_count(perf_miss_count), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_nop();
        valid_mem = 0; load_mem = 0; store_mem = 0; is_word_mem = 1;
        addr_mem = 0; store_data_mem = 0; rd_num_mem = 0;
        register_write_mem = 0; halted_mem = 0;
        cache_hit = 1; cache_dirty = 0; cache_victim_addr = 0;
        cache_rdata = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        rst_b = 1; drive_nop();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (wb_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        n_cmp++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_wb_reg_write got %b want 0", wb_reg_write); end
        n_cmp++; if (wb_data !== 32'd0)     begin n_fail++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
        n_cmp++; if (mem_req !== 1'b0)      begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_cmp++; if (stall !== 1'b0)        begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
        n_cmp++; if (cache_we !== 1'b0)     begin n_fail++; $display("FAIL reset_cache_we got %b want 0", cache_we); end
`ifdef MEM_STAGE_PERF_EN
        n_cmp++; if (perf_miss_count !== 32'd0) begin n_fail++; $display("FAIL reset_perf_miss got %0d want 0", perf_miss_count); end
`endif
        @(negedge clk); rst_b = 0;
    endtask

    task automatic test_word_load_hit();
        @(negedge clk);
        valid_mem = 1; load_mem = 1; is_word_mem = 1; addr_mem = 32'h100;
        cache_hit = 1; cache_rdata = 32'hDEADBEEF; rd_num_mem = 5'd5; register_write_mem = 1;
        #1;
        n_cmp++; if (stall !== 1'b0)    begin n_fail++; $display("FAIL wload_stall got %b want 0", stall); end
        n_cmp++; if (cache_we !== 1'b0) begin n_fail++; $display("FAIL wload_cache_we got %b want 0", cache_we); end
        @(posedge clk); #1;
        n_cmp++; if (wb_valid !== 1'b1)        begin n_fail++; $display("FAIL wload_wb_valid got %b want 1", wb_valid); end
        n_cmp++; if (wb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wload_wb_data got %h want deadbeef", wb_data); end
        n_cmp++; if (wb_rd !== 5'd5)           begin n_fail++; $display("FAIL wload_wb_rd got %0d want 5", wb_rd); end
        n_cmp++; if (wb_reg_write !== 1'b1)    begin n_fail++; $display("FAIL wload_wb_reg_write got %b want 1", wb_reg_write); end
    endtask

    task automatic test_byte_load_hit();
        @(negedge clk);
        valid_mem = 1; load_mem = 1; is_word_mem = 0; addr_mem = 32'h103;
        cache_hit = 1; cache_rdata = 32'h80112233;
        @(posedge clk); #1;
        n_cmp++; if (wb_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL bload_103 got %h want ffffff80", wb_data); end
        @(negedge clk); addr_mem = 32'h101;
        @(posedge clk); #1;
        n_cmp++; if (wb_data !== 32'h00000022) begin n_fail++; $display("FAIL bload_101 got %h want 00000022", wb_data); end
    endtask

    task automatic test_load_store_both();
        @(negedge clk);
        drive_nop();
        valid_mem = 1; load_mem = 1; store_mem = 1; is_word_mem = 1; addr_mem = 32'h104;
        cache_rdata = 32'h01020304; store_data_mem = 32'h55555555;
        #1;
        n_cmp++; if (cache_we !== 1'b0) begin n_fail++; $display("FAIL both_cache_we got %b want 0", cache_we); end
        @(posedge clk); #1;
        n_cmp++; if (wb_data !== 32'h01020304) begin n_fail++; $display("FAIL both_wb_data got %h want 01020304", wb_data); end
    endtask

    task automatic test_byte_store_hit();
        @(negedge clk);
        drive_nop();
        valid_mem = 1; store_mem = 1; is_word_mem = 0; addr_mem = 32'h42; store_data_mem = 32'h000000AB;
        #1;
        n_cmp++; if (stall !== 1'b0)               begin n_fail++; $display("FAIL bstore_stall got %b want 0", stall); end
        n_cmp++; if (cache_we !== 1'b1)            begin n_fail++; $display("FAIL bstore_we got %b want 1", cache_we); end
        n_cmp++; if (cache_byte_en !== 4'b0100)    begin n_fail++; $display("FAIL bstore_byte_en got %b want 0100", cache_byte_en); end
        n_cmp++; if (cache_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL bstore_wdata got %h want abababab", cache_wdata); end
        n_cmp++; if (cache_set_dirty !== 1'b1)     begin n_fail++; $display("FAIL bstore_dirty got %b want 1", cache_set_dirty); end
        n_cmp++; if (cache_input_type !== 1'b0)    begin n_fail++; $display("FAIL bstore_itype got %b want 0", cache_input_type); end
        @(posedge clk); #1;
        n_cmp++; if (wb_data !== 32'h42) begin n_fail++; $display("FAIL bstore_wb_data got %h want 42", wb_data); end
        @(negedge clk); drive_nop(); #1;
        n_cmp++; if (cache_we !== 1'b0) begin n_fail++; $display("FAIL bstore_single got %b want 0", cache_we); end
    endtask

    task automatic test_clean_load_miss();
        int stall_n = 0, we_n = 0, rd_n = 0, wr_n = 0, bad_addr = 0, wbv_n = 0, halt_n = 0;
        bit done = 0, refill_seen = 0;
        @(negedge clk);
        drive_nop();
        valid_mem = 1; load_mem = 1; is_word_mem = 1; addr_mem = 32'h300; rd_num_mem = 5'd7;
        register_write_mem = 1; halted_mem = 1; cache_hit = 0; cache_dirty = 0;
        cache_rdata = 32'h0; mem_rdata = 32'h12345678;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (refill_seen) begin cache_hit = 1; cache_rdata = 32'h12345678; end
            end
            #1;
            if (!stall) done = 1;
            else begin
                stall_n++;
                if (wb_valid) wbv_n++;
                if (wb_halted) halt_n++;
                if (mem_req && !mem_we) begin rd_n++; if (mem_addr !== 32'h300) bad_addr++; end
                if (mem_req && mem_we) wr_n++;
                if (cache_we) begin
                    we_n++; refill_seen = 1;
                    n_cmp++; if (cache_input_type !== 1'b1) begin n_fail++; $display("FAIL cmiss_itype got %b want 1", cache_input_type); end
                    n_cmp++; if (cache_wdata !== 32'h12345678) begin n_fail++; $display("FAIL cmiss_wdata got %h want 12345678", cache_wdata); end
                    n_cmp++; if (cache_set_dirty !== 1'b0 || cache_set_valid !== 1'b1 || cache_byte_en !== 4'b1111) begin
                        n_fail++; $display("FAIL cmiss_refill_bits got d=%b v=%b be=%b want d=0 v=1 be=1111", cache_set_dirty, cache_set_valid, cache_byte_en); end
                end
            end
        end
        n_cmp++; if (!done)         begin n_fail++; $display("FAIL cmiss_timeout got stall stuck want release"); end
        n_cmp++; if (stall_n !== 5) begin n_fail++; $display("FAIL cmiss_stall_len got %0d want 5", stall_n); end
        n_cmp++; if (we_n !== 1)    begin n_fail++; $display("FAIL cmiss_refill_cnt got %0d want 1", we_n); end
        n_cmp++; if (rd_n !== 4 || wr_n !== 0 || bad_addr !== 0) begin
            n_fail++; $display("FAIL cmiss_mem got rd=%0d wr=%0d bad=%0d want 4/0/0", rd_n, wr_n, bad_addr); end
        n_cmp++; if (wbv_n !== 0 || halt_n !== 0) begin n_fail++; $display("FAIL cmiss_bubble got v=%0d h=%0d want 0/0", wbv_n, halt_n); end
        @(posedge clk); #1;
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h12345678 || wb_rd !== 5'd7) begin
            n_fail++; $display("FAIL cmiss_replay got v=%b d=%h rd=%0d want 1/12345678/7", wb_valid, wb_data, wb_rd); end
        n_cmp++; if (wb_halted !== 1'b1) begin n_fail++; $display("FAIL cmiss_halt got %b want 1", wb_halted); end
        @(negedge clk); drive_nop();
        @(posedge clk); #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL cmiss_one_pulse got %b want 0", wb_valid); end
    endtask

    task automatic test_dirty_store_miss();
        int stall_n = 0, rd_n = 0, wr_n = 0, bad = 0;
        bit done = 0, refill_seen = 0;
`ifdef MEM_STAGE_PERF_EN
        logic [31:0] miss0, stall0;
        miss0 = perf_miss_count; stall0 = perf_stall_cycles;
`endif
        @(negedge clk);
        drive_nop();
        valid_mem = 1; store_mem = 1; is_word_mem = 1; addr_mem = 32'h500; store_data_mem = 32'hCAFEF00D;
        cache_hit = 0; cache_dirty = 1; cache_victim_addr = 32'h200; cache_rdata = 32'h0BADBEEF;
        mem_rdata = 32'h77776666;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                cache_victim_addr = 32'hFFFFFFF0;
                if (refill_seen) begin cache_hit = 1; cache_dirty = 0; end
            end
            #1;
            if (!stall) done = 1;
            else begin
                stall_n++;
                if (mem_req && mem_we) begin
                    if (rd_n != 0) bad++;
                    wr_n++; if (mem_addr !== 32'h200 || mem_wdata !== 32'h0BADBEEF) bad++;
                end
                if (mem_req && !mem_we) begin rd_n++; if (mem_addr !== 32'h500) bad++; end
                if (cache_we) refill_seen = 1;
            end
        end
        n_cmp++; if (!done)         begin n_fail++; $display("FAIL dmiss_timeout got stall stuck want release"); end
        n_cmp++; if (stall_n !== 9) begin n_fail++; $display("FAIL dmiss_stall_len got %0d want 9", stall_n); end
        n_cmp++; if (wr_n !== 4 || rd_n !== 4 || bad !== 0) begin
            n_fail++; $display("FAIL dmiss_mem got wr=%0d rd=%0d bad=%0d want 4/4/0", wr_n, rd_n, bad); end
        n_cmp++; if (cache_we !== 1'b1 || cache_input_type !== 1'b0 || cache_byte_en !== 4'b1111 ||
                     cache_wdata !== 32'hCAFEF00D || cache_set_dirty !== 1'b1) begin
            n_fail++; $display("FAIL dmiss_replay_store got we=%b it=%b be=%b wd=%h d=%b want 1/0/1111/cafef00d/1",
                               cache_we, cache_input_type, cache_byte_en, cache_wdata, cache_set_dirty); end
        @(posedge clk); #1;
`ifdef MEM_STAGE_PERF_EN
        n_cmp++; if (perf_miss_count - miss0 !== 32'd1) begin n_fail++; $display("FAIL perf_miss got %0d want 1", perf_miss_count - miss0); end
        n_cmp++; if (perf_stall_cycles - stall0 !== 32'd9) begin n_fail++; $display("FAIL perf_stall got %0d want 9", perf_stall_cycles - stall0); end
`endif
        @(negedge clk); drive_nop();
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        drive_nop();
        valid_mem = 1; addr_mem = 32'h1234; rd_num_mem = 5'd9; register_write_mem = 1; halted_mem = 1;
        cache_hit = 0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL pass_stall got %b want 0", stall); end
        @(posedge clk); #1;
        n_cmp++; if (wb_data !== 32'h1234 || wb_rd !== 5'd9 || wb_halted !== 1'b1 || wb_reg_write !== 1'b1) begin
            n_fail++; $display("FAIL pass_wb got d=%h rd=%0d h=%b rw=%b want 1234/9/1/1", wb_data, wb_rd, wb_halted, wb_reg_write); end
    endtask

    task automatic test_reset_mid_refill();
        @(negedge clk);
        drive_nop();
        valid_mem = 1; load_mem = 1; addr_mem = 32'h700; rd_num_mem = 5'd3;
        cache_hit = 0; cache_dirty = 0;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rmid_miss_stall got %b want 1", stall); end
        @(negedge clk); #1;
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_refill got %b want 1", mem_req); end
        @(negedge clk);
        rst_b = 1; drive_nop();
        #1;
        n_cmp++; if (cache_we !== 1'b0) begin n_fail++; $display("FAIL rmid_no_write got %b want 0", cache_we); end
        @(posedge clk); #1;
        n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0 || cache_we !== 1'b0) begin
            n_fail++; $display("FAIL rmid_idle got req=%b st=%b we=%b want 0/0/0", mem_req, stall, cache_we); end
        n_cmp++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || wb_halted !== 1'b0) begin
            n_fail++; $display("FAIL rmid_wb got v=%b rw=%b rd=%0d d=%h h=%b want all 0", wb_valid, wb_reg_write, wb_rd, wb_data, wb_halted); end
        @(negedge clk); rst_b = 0;
    endtask

    initial begin
        test_reset();
        test_word_load_hit();
        test_byte_load_hit();
        test_load_store_both();
        test_byte_store_hit();
        test_clean_load_miss();
        test_dirty_store_miss();
        test_passthrough();
        test_reset_mid_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
